// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed digit scan controller.
package display_pkg;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {SCAN_OFF, SCAN_BLANK, SCAN_SHOW} scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// Application-side bundle of the scan controller: value/control in, decoder/driver outputs back.
interface display_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
    import display_pkg::*;

    logic                          enable;
    logic [BCD_W*NUM_DIGITS-1:0]   value;
    logic                          load;
    logic                          blank_lz;
    logic [BCD_W-1:0]              digit;
    logic [NUM_DIGITS-1:0]         digit_sel;
    logic                          frame_done;

    modport master (
        output enable, value, load, blank_lz,
        input  digit, digit_sel, frame_done
    );

    modport slave (
        input  enable, value, load, blank_lz,
        output digit, digit_sel, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Scans a double-buffered BCD value across NUM_DIGITS positions with dead time
// between digits and optional leading-zero blanking.
//
// state      | meaning
// SCAN_OFF   | display dark, waiting for enable
// SCAN_BLANK | all selects off, decoder settling on the next digit
// SCAN_SHOW  | current position lit (unless leading-zero blanked)
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 20000,
    parameter int DEAD_CYCLES = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);
    localparam int TIMER_W = $clog2(max_int(SCAN_DIV, DEAD_CYCLES) + 1);
    localparam int POS_W   = $clog2(NUM_DIGITS);
    localparam int VAL_W   = BCD_W * NUM_DIGITS;

    scan_state_t            state;
    logic [POS_W-1:0]       pos;
    logic [TIMER_W-1:0]     timer;
    logic [VAL_W-1:0]       shadow;
    logic [VAL_W-1:0]       active;
    logic                   pending;
    logic [NUM_DIGITS-1:0]  lz_mask;
    logic                   seen_nz;

    function automatic logic [BCD_W-1:0] nib(input logic [VAL_W-1:0] v, input int idx);
        return v[idx*BCD_W +: BCD_W];
    endfunction

    // Scan from the MSD down: a position is blanked until a non-zero nibble is seen.
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nz    = seen_nz | (active[i*BCD_W +: BCD_W] != '0);
            lz_mask[i] = bus.blank_lz & ~seen_nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SCAN_OFF;
            pos            <= '0;
            timer          <= '0;
            shadow         <= '0;
            active         <= '0;
            pending        <= 1'b0;
            bus.digit      <= '0;
            bus.digit_sel  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (!bus.enable) begin
                state         <= SCAN_OFF;
                bus.digit     <= '0;
                bus.digit_sel <= '0;
            end else begin
                case (state)
                    SCAN_OFF: begin
                        state         <= SCAN_BLANK;
                        pos           <= '0;
                        timer         <= '0;
                        active        <= shadow;
                        pending       <= 1'b0;
                        bus.digit     <= shadow[BCD_W-1:0];
                        bus.digit_sel <= '0;
                    end
                    SCAN_BLANK: begin
                        if (timer == TIMER_W'(DEAD_CYCLES - 1)) begin
                            state         <= SCAN_SHOW;
                            timer         <= '0;
                            bus.digit_sel <= lz_mask[pos] ? '0 : (NUM_DIGITS'(1) << pos);
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    SCAN_SHOW: begin
                        if (timer == TIMER_W'(SCAN_DIV - 1)) begin
                            state         <= SCAN_BLANK;
                            timer         <= '0;
                            bus.digit_sel <= '0;
                            if (pos == POS_W'(NUM_DIGITS - 1)) begin
                                pos            <= '0;
                                bus.frame_done <= 1'b1;
                                // Shadow only reaches the display at a frame boundary.
                                if (pending) begin
                                    active    <= shadow;
                                    pending   <= 1'b0;
                                    bus.digit <= shadow[BCD_W-1:0];
                                end else begin
                                    bus.digit <= active[BCD_W-1:0];
                                end
                            end else begin
                                pos       <= pos + 1'b1;
                                bus.digit <= nib(active, int'(pos) + 1);
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= SCAN_OFF;
                endcase
            end
            // A load on the wrap edge lands in shadow and waits for the next frame.
            if (bus.load) begin
                shadow  <= bus.value;
                pending <= 1'b1;
            end
        end
    end
endmodule
